// File: rtl/cpu_timing_pkg.sv
// Shared machine-cycle timing definitions: sequencer state encoding and default geometry.
package cpu_timing_pkg;

  localparam int unsigned NSTATES_DEF   = 8;
  localparam int unsigned TW_DEF        = 3;
  localparam int unsigned WAIT_SLOT_DEF = 2;

  typedef enum logic [1:0] {
    ST_ALIGN  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/phase_edge.sv
// Rising-edge detector for one phase level: combinational rise plus a registered 1-CLK strobe.
module phase_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ph,
  output logic o_rise_c,
  output logic o_stb
);

  logic r_ph_q;

  assign o_rise_c = i_ph & ~r_ph_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ph_q <= 1'b0;
      o_stb  <= 1'b0;
    end else begin
      r_ph_q <= i_ph;
      o_stb  <= o_rise_c;
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// Machine-cycle sequencer driven by the PH1/PH2 phase pair: subcycle counter, SYNC, HALT, overlap flag.
// Optional stall at WAIT_SLOT is built when WAIT_STATE_EN is defined.
module cycle_sequencer
  import cpu_timing_pkg::*;
#(
  parameter int unsigned NSTATES   = NSTATES_DEF,
  parameter int unsigned TW        = TW_DEF,
  parameter int unsigned WAIT_SLOT = WAIT_SLOT_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               PH1,
  input  logic               PH2,
  input  logic               HALT,
`ifdef WAIT_STATE_EN
  input  logic               WAIT,
`endif
  output logic [TW-1:0]      TSTATE,
  output logic [NSTATES-1:0] TONEHOT,
  output logic               SYNC,
  output logic               PH1_STB,
  output logic               PH2_STB,
  output logic               HALTED,
  output logic               OVL_ERR
);

  seq_state_e          r_state;
  seq_state_e          w_state_nx;
  logic [TW-1:0]       r_tstate;
  logic [TW-1:0]       w_tstate_nx;
  logic [NSTATES-1:0]  r_onehot;
  logic [NSTATES-1:0]  w_onehot_nx;
  logic                r_sync;
  logic                w_sync_nx;
  logic                r_halted;
  logic                r_ovl;
  logic                w_rise1;
  logic                w_rise2;
  logic                w_ovl;
  logic                w_adv1;
  logic                w_adv2;
  logic                w_wait;
  logic                w_stall;
  logic                w_at_last;

  phase_edge u_edge_ph1 (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_ph     (PH1),
    .o_rise_c (w_rise1),
    .o_stb    (PH1_STB)
  );

  phase_edge u_edge_ph2 (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_ph     (PH2),
    .o_rise_c (w_rise2),
    .o_stb    (PH2_STB)
  );

`ifdef WAIT_STATE_EN
  assign w_wait = WAIT;
`else
  assign w_wait = 1'b0;
`endif

  // A sampled overlap voids both rises for that cycle so the counter never moves on a bad phase pair
  assign w_ovl     = PH1 & PH2;
  assign w_adv1    = w_rise1 & ~w_ovl;
  assign w_adv2    = w_rise2 & ~w_ovl;
  assign w_stall   = w_wait & (r_tstate == TW'(WAIT_SLOT));
  assign w_at_last = (r_tstate == TW'(NSTATES - 1));

  // Next-state, next-subcycle and next-output decode
  always_comb begin
    w_state_nx  = r_state;
    w_tstate_nx = r_tstate;
    w_sync_nx   = 1'b0;
    w_onehot_nx = '0;
    unique case (r_state)
      ST_ALIGN: begin
        if (w_adv1) begin
          w_state_nx  = ST_RUN;
          w_tstate_nx = '0;
          w_sync_nx   = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_adv2 && !w_stall) begin
          if (w_at_last) begin
            w_tstate_nx = '0;
            if (HALT) begin
              w_state_nx = ST_HALTED;
            end else begin
              w_sync_nx = 1'b1;
            end
          end else begin
            w_tstate_nx = r_tstate + TW'(1);
          end
        end
      end
      ST_HALTED: begin
        if (w_adv2 && !HALT) begin
          w_state_nx  = ST_RUN;
          w_tstate_nx = '0;
          w_sync_nx   = 1'b1;
        end
      end
      default: begin
        w_state_nx  = ST_ALIGN;
        w_tstate_nx = '0;
      end
    endcase
    if (w_state_nx == ST_RUN) begin
      w_onehot_nx = NSTATES'(1) << w_tstate_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_ALIGN;
      r_tstate <= '0;
      r_onehot <= '0;
      r_sync   <= 1'b0;
      r_halted <= 1'b0;
      r_ovl    <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tstate <= w_tstate_nx;
      r_onehot <= w_onehot_nx;
      r_sync   <= w_sync_nx;
      r_halted <= (w_state_nx == ST_HALTED);
      r_ovl    <= r_ovl | w_ovl;
    end
  end

  assign TSTATE  = r_tstate;
  assign TONEHOT = r_onehot;
  assign SYNC    = r_sync;
  assign HALTED  = r_halted;
  assign OVL_ERR = r_ovl;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Self-checking bench for cycle_sequencer: startup vector table, then hand-built phase sequences.
module tb_cycle_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PH1 = 1'b0;
  logic       PH2 = 1'b0;
  logic       HALT = 1'b0;
  logic       drv_wait = 1'b0;
`ifdef WAIT_STATE_EN
  logic       WAIT;
  assign WAIT = drv_wait;
`endif
  logic [2:0] TSTATE;
  logic [7:0] TONEHOT;
  logic       SYNC, PH1_STB, PH2_STB, HALTED, OVL_ERR;

  always #5 CLK = ~CLK;

  cycle_sequencer dut (
    .CLK     (CLK),
    .RST     (RST),
    .PH1     (PH1),
    .PH2     (PH2),
    .HALT    (HALT),
`ifdef WAIT_STATE_EN
    .WAIT    (WAIT),
`endif
    .TSTATE  (TSTATE),
    .TONEHOT (TONEHOT),
    .SYNC    (SYNC),
    .PH1_STB (PH1_STB),
    .PH2_STB (PH2_STB),
    .HALTED  (HALTED),
    .OVL_ERR (OVL_ERR)
  );

  typedef struct {
    logic [2:0] t;
    logic       run;
    logic       sync;
    logic       hlt;
    logic       ovl;
    logic       s1;
    logic       s2;
    logic       chk_stb;
  } exp_s;

  typedef struct {
    logic rst;
    logic p1;
    logic p2;
    logic h;
    exp_s e;
  } vec_s;

  exp_s       sb_q[$];
  vec_s       vt[12];
  int         n_chk = 0;
  int         n_pass = 0;
  int         sync_seen = 0;
  int         step_no = 0;
  logic [2:0] cur_t = 3'd0;
  logic       cur_run = 1'b0;
  logic       cur_hlt = 1'b0;
  logic       e_ovl = 1'b0;

  function automatic exp_s mk(input logic [2:0] t, input logic run, sync, hlt, ovl, s1, s2);
    exp_s e;
    e.t = t; e.run = run; e.sync = sync; e.hlt = hlt; e.ovl = ovl;
    e.s1 = s1; e.s2 = s2; e.chk_stb = 1'b1;
    return e;
  endfunction

  function automatic vec_s mkv(input logic rst, p1, p2, h, input exp_s e);
    vec_s v;
    v.rst = rst; v.p1 = p1; v.p2 = p2; v.h = h; v.e = e;
    return v;
  endfunction

  task automatic check_out();
    exp_s       e;
    logic [7:0] oh;
    logic       ok;
    e  = sb_q.pop_front();
    oh = e.run ? (8'(1) << e.t) : 8'd0;
    n_chk++;
    if (SYNC) sync_seen++;
    ok = (TSTATE == e.t) && (TONEHOT == oh) && (SYNC == e.sync) && (HALTED == e.hlt) &&
         (OVL_ERR == e.ovl) && (!e.chk_stb || (PH1_STB == e.s1 && PH2_STB == e.s2));
    if (ok) n_pass++;
    else $display("FAIL step%0d: got t=%0d oh=%b sync=%b halted=%b ovl=%b stb=%b%b, want t=%0d oh=%b sync=%b halted=%b ovl=%b stb=%b%b",
                  step_no, TSTATE, TONEHOT, SYNC, HALTED, OVL_ERR, PH1_STB, PH2_STB,
                  e.t, oh, e.sync, e.hlt, e.ovl, e.s1, e.s2);
  endtask

  // Drive one CLK worth of inputs, queue the expected outputs, compare just after the edge
  task automatic drive_step(input logic rst, p1, p2, h, input exp_s e);
    @(negedge CLK);
    RST = rst; PH1 = p1; PH2 = p2; HALT = h;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    step_no++;
    check_out();
  endtask

  // One phase period: PH1 high, gap, PH2 high (the advancing edge), gap
  task automatic period(input logic h, input logic [2:0] nt, input logic nrun, nsync, nhlt);
    drive_step(1'b0, 1'b1, 1'b0, h, mk(cur_t, cur_run, 1'b0, cur_hlt, e_ovl, 1'b1, 1'b0));
    drive_step(1'b0, 1'b0, 1'b0, h, mk(cur_t, cur_run, 1'b0, cur_hlt, e_ovl, 1'b0, 1'b0));
    drive_step(1'b0, 1'b0, 1'b1, h, mk(nt, nrun, nsync, nhlt, e_ovl, 1'b0, 1'b1));
    drive_step(1'b0, 1'b0, 1'b0, h, mk(nt, nrun, 1'b0, nhlt, e_ovl, 1'b0, 1'b0));
    cur_t = nt; cur_run = nrun; cur_hlt = nhlt;
  endtask

  task automatic advance();
    period(1'b0, 3'(cur_t + 3'd1), 1'b1, (cur_t == 3'd7), 1'b0);
  endtask

  task automatic run_to(input logic [2:0] target);
    for (int i = 0; i < 8 && cur_t != target; i++) advance();
  endtask

  initial begin
    vt[0]  = mkv(1, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0));
    vt[1]  = mkv(1, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0));
    vt[2]  = mkv(0, 0, 1, 0, mk(3'd0, 0, 0, 0, 0, 0, 1));  // rise2 in ALIGN: no advance
    vt[3]  = mkv(0, 0, 0, 0, mk(3'd0, 0, 0, 0, 0, 0, 0));
    vt[4]  = mkv(0, 1, 0, 0, mk(3'd0, 1, 1, 0, 0, 1, 0));  // first rise1: RUN, SYNC
    vt[5]  = mkv(0, 0, 0, 0, mk(3'd0, 1, 0, 0, 0, 0, 0));
    vt[6]  = mkv(0, 0, 1, 0, mk(3'd1, 1, 0, 0, 0, 0, 1));
    vt[7]  = mkv(0, 0, 0, 0, mk(3'd1, 1, 0, 0, 0, 0, 0));
    vt[8]  = mkv(0, 1, 0, 0, mk(3'd1, 1, 0, 0, 0, 1, 0));
    vt[9]  = mkv(0, 0, 0, 0, mk(3'd1, 1, 0, 0, 0, 0, 0));
    vt[10] = mkv(0, 0, 1, 0, mk(3'd2, 1, 0, 0, 0, 0, 1));
    vt[11] = mkv(0, 0, 0, 0, mk(3'd2, 1, 0, 0, 0, 0, 0));

    for (int i = 0; i < 12; i++) drive_step(vt[i].rst, vt[i].p1, vt[i].p2, vt[i].h, vt[i].e);
    cur_t = 3'd2; cur_run = 1'b1; cur_hlt = 1'b0;

    // Four complete machine cycles must give exactly four SYNC pulses
    sync_seen = 0;
    for (int i = 0; i < 32; i++) advance();
    n_chk++;
    if (sync_seen == 4) n_pass++;
    else $display("FAIL sync_count: got %0d pulses, want 4", sync_seen);

    // HALT held from T5: ignored until the wrap, then HALTED until released
    run_to(3'd5);
    period(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    period(1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    period(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    period(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    period(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);

    // Phase overlap at T3: sticky error, no advance on that cycle
    run_to(3'd3);
    drive_step(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd3, 1, 0, 0, 0, 1, 0));
    begin
      exp_s e;
      e = mk(3'd3, 1, 0, 0, 1, 0, 0);
      e.chk_stb = 1'b0;
      drive_step(1'b0, 1'b1, 1'b1, 1'b0, e);
    end
    e_ovl = 1'b1;
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd3, 1, 0, 0, 1, 0, 0));
    advance();
    run_to(3'd6);

    // Reset at T6 clears everything; rise2 before rise1 must not advance
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0));
    e_ovl = 1'b0;
    drive_step(1'b0, 1'b0, 1'b1, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 1));
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 0, 0, 0, 0, 0, 0));
    drive_step(1'b0, 1'b1, 1'b0, 1'b0, mk(3'd0, 1, 1, 0, 0, 1, 0));
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, mk(3'd0, 1, 0, 0, 0, 0, 0));
    cur_t = 3'd0; cur_run = 1'b1; cur_hlt = 1'b0;
    advance();

`ifdef WAIT_STATE_EN
    // WAIT at the wait slot holds the subcycle for three rise2s
    run_to(3'd2);
    drv_wait = 1'b1;
    for (int i = 0; i < 3; i++) period(1'b0, 3'd2, 1'b1, 1'b0, 1'b0);
    drv_wait = 1'b0;
    period(1'b0, 3'd3, 1'b1, 1'b0, 1'b0);
`endif
    run_to(3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
